// File: rtl/qmax_update_table.sv
// qmax_update_table
//   Per-state max-Q table. A single write port is shared by a clear sweep and
//   a 2-stage update pipeline (S0 capture + sync read, S1 compare + commit).
//   A separate registered read port returns data one cycle after a request.
//
// Ports
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_clear / o_busy                start clear sweep / sweep in progress
//   i_rd_en, i_rd_addr              read request
//   o_rd_data, o_rd_valid           registered read result
//   i_upd_en, i_upd_addr,
//   i_upd_data, i_upd_mode          update request (0 = write, 1 = max)
//   o_improved                      max update raised the stored value
//
// FSM
//   state    | meaning
//   ST_CLEAR | writing INIT_VALUE to mem[cnt], one entry per cycle; inputs ignored
//   ST_IDLE  | accepting reads and updates
module qmax_update_table #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    IS_FLOAT   = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  output logic                  o_busy,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_upd_en,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [DATA_WIDTH-1:0] i_upd_data,
  input  logic                  i_upd_mode,
  output logic                  o_improved
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    s1_valid_q;
  logic                    s1_mode_q;
  logic [ADDR_WIDTH-1:0]   s1_addr_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic [DATA_WIDTH-1:0]   s1_old_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    improved_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    cand_gt;
  logic                    commit;
  logic                    improved_d;
  logic                    rd_in_range;
  logic                    upd_in_range;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic [DATA_WIDTH-1:0]   upd_old_d;

  // Maps IEEE-754 bit patterns onto an unsigned order: negatives are inverted
  // so larger magnitude sorts lower, positives get the sign bit set.
  function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] x);
    fkey = x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
  endfunction

  always_comb begin
    cand_gt = 1'b0;
    if (IS_FLOAT != 0) cand_gt = fkey(s1_data_q) > fkey(s1_old_q);
    else               cand_gt = $signed(s1_data_q) > $signed(s1_old_q);
  end

  // i_clear in IDLE both blocks new requests and squashes the S1 commit.
  assign accept     = (state_q == ST_IDLE) && !i_clear;
  assign commit     = s1_valid_q && accept && (!s1_mode_q || cand_gt);
  assign improved_d = s1_valid_q && accept && s1_mode_q && cand_gt;

  assign rd_in_range  = {1'b0, i_rd_addr} < DEPTH_L;
  assign upd_in_range = {1'b0, i_upd_addr} < DEPTH_L;

  // Forward the value being committed this edge so both ports observe every
  // update accepted in an earlier cycle. A committed value is always s1_data_q.
  always_comb begin
    rd_data_d = INIT_VALUE;
    if (rd_in_range) begin
      if (commit && (s1_addr_q == i_rd_addr)) rd_data_d = s1_data_q;
      else                                    rd_data_d = mem[i_rd_addr];
    end
  end

  always_comb begin
    upd_old_d = INIT_VALUE;
    if (upd_in_range) begin
      if (commit && (s1_addr_q == i_upd_addr)) upd_old_d = s1_data_q;
      else                                     upd_old_d = mem[i_upd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == ST_CLEAR) mem[cnt_q]     <= INIT_VALUE;
    else if (commit)         mem[s1_addr_q] <= s1_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_old_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      improved_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_IDLE: begin
          if (i_clear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase

      s1_valid_q <= accept && i_upd_en && upd_in_range;
      if (accept && i_upd_en) begin
        s1_mode_q <= i_upd_mode;
        s1_addr_q <= i_upd_addr;
        s1_data_q <= i_upd_data;
        s1_old_q  <= upd_old_d;
      end

      rd_valid_q <= accept && i_rd_en;
      if (accept && i_rd_en) rd_data_q <= rd_data_d;

      improved_q <= improved_d;
    end
  end

  assign o_busy     = (state_q == ST_CLEAR);
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_improved = improved_q;

endmodule

// File: tb/tb_qmax_update_table.sv
module tb_qmax_update_table;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_rd_en = 1'b0;
  logic [5:0]  i_rd_addr = '0;
  logic        i_upd_en = 1'b0;
  logic [5:0]  i_upd_addr = '0;
  logic [31:0] i_upd_data = '0;
  logic        i_upd_mode = 1'b0;

  logic        busy_f, rd_valid_f, imp_f;
  logic [31:0] rd_data_f;
  logic        busy_i, rd_valid_i, imp_i;
  logic [31:0] rd_data_i;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  qmax_update_table #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .IS_FLOAT(1),
                      .INIT_VALUE(32'h0)) dut_f (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .o_busy(busy_f),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(rd_data_f),
    .o_rd_valid(rd_valid_f), .i_upd_en(i_upd_en), .i_upd_addr(i_upd_addr),
    .i_upd_data(i_upd_data), .i_upd_mode(i_upd_mode), .o_improved(imp_f));

  qmax_update_table #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .IS_FLOAT(0),
                      .INIT_VALUE(32'h0)) dut_i (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .o_busy(busy_i),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(rd_data_i),
    .o_rd_valid(rd_valid_i), .i_upd_en(i_upd_en), .i_upd_addr(i_upd_addr),
    .i_upd_data(i_upd_data), .i_upd_mode(i_upd_mode), .o_improved(imp_i));

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic upd(input logic [5:0] a, input logic [31:0] d, input logic m);
    i_upd_en = 1'b1; i_upd_addr = a; i_upd_data = d; i_upd_mode = m;
    cyc();
    i_upd_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic v,
                    output logic imp, output logic [31:0] di, output logic impi);
    i_rd_en = 1'b1; i_rd_addr = a;
    cyc();
    i_rd_en = 1'b0;
    d = rd_data_f; v = rd_valid_f; imp = imp_f; di = rd_data_i; impi = imp_i;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_f && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] d, di;
    logic v, imp, impi;
    logic [5:0] addrs [3];
    addrs[0] = 6'd0; addrs[1] = 6'd37; addrs[2] = 6'd63;
    i_rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (busy_f !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_f); end
    checks++; if (rd_valid_f !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid_f); end
    checks++; if (imp_f !== 1'b0) begin errors++; $display("FAIL reset_improved: got %b expected 0", imp_f); end
    checks++; if (rd_data_f !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data_f); end
    i_rst_n = 1'b1;
    count_busy(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL reset_sweep_len: got %0d expected 64", n); end
    for (int k = 0; k < 3; k++) begin
      rd(addrs[k], d, v, imp, di, impi);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin
        errors++; $display("FAIL init_read_%0d: got valid=%b data=%h expected valid=1 data=00000000", addrs[k], v, d);
      end
    end
    cyc();
    checks++; if (rd_valid_f !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid_f); end
  endtask

  task automatic test_plain_max();
    logic [31:0] d, di;
    logic v, imp, impi;
    upd(6'd5, 32'h40400000, 1'b0);
    rd(6'd5, d, v, imp, di, impi);
    checks++; if (d !== 32'h40400000 || imp !== 1'b0) begin
      errors++; $display("FAIL write_3p0: got data=%h imp=%b expected 40400000 imp=0", d, imp);
    end
    upd(6'd5, 32'h40000000, 1'b1);
    rd(6'd5, d, v, imp, di, impi);
    checks++; if (d !== 32'h40400000 || imp !== 1'b0) begin
      errors++; $display("FAIL max_2p0: got data=%h imp=%b expected 40400000 imp=0", d, imp);
    end
    upd(6'd5, 32'h40800000, 1'b1);
    rd(6'd5, d, v, imp, di, impi);
    checks++; if (d !== 32'h40800000 || imp !== 1'b1) begin
      errors++; $display("FAIL max_4p0: got data=%h imp=%b expected 40800000 imp=1", d, imp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, di;
    logic v, imp, impi;
    logic [2:0] pat;
    i_upd_en = 1'b1; i_upd_addr = 6'd9; i_upd_mode = 1'b1;
    i_upd_data = 32'h3F800000; cyc();
    i_upd_data = 32'h3F000000; cyc(); pat[2] = imp_f;
    i_upd_data = 32'h40000000; cyc(); pat[1] = imp_f;
    i_upd_en = 1'b0;           cyc(); pat[0] = imp_f;
    checks++; if (pat !== 3'b101) begin errors++; $display("FAIL b2b_improved: got %b expected 101", pat); end
    rd(6'd9, d, v, imp, di, impi);
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL b2b_final: got %h expected 40000000", d); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d, di;
    logic v, imp, impi;
    i_upd_en = 1'b1; i_upd_addr = 6'd12; i_upd_data = 32'h12345678; i_upd_mode = 1'b0;
    rd(6'd12, d, v, imp, di, impi);
    i_upd_en = 1'b0;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL same_cycle_old: got %h expected 00000000", d); end
    rd(6'd12, d, v, imp, di, impi);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL same_cycle_new: got %h expected 12345678", d); end
  endtask

  task automatic test_negative();
    logic [31:0] d, di;
    logic v, imp, impi;
    upd(6'd20, 32'hC0000000, 1'b0);
    upd(6'd20, 32'hBF800000, 1'b1);
    rd(6'd20, d, v, imp, di, impi);
    checks++; if (d !== 32'hBF800000 || imp !== 1'b1) begin
      errors++; $display("FAIL neg_float: got data=%h imp=%b expected BF800000 imp=1", d, imp);
    end
    upd(6'd22, 32'h00000000, 1'b0);
    upd(6'd22, 32'h80000000, 1'b1);
    rd(6'd22, d, v, imp, di, impi);
    checks++; if (d !== 32'h00000000 || imp !== 1'b0) begin
      errors++; $display("FAIL negzero_vs_poszero: got data=%h imp=%b expected 00000000 imp=0", d, imp);
    end
    upd(6'd22, 32'h80000000, 1'b0);
    upd(6'd22, 32'h00000000, 1'b1);
    rd(6'd22, d, v, imp, di, impi);
    checks++; if (d !== 32'h00000000 || imp !== 1'b1) begin
      errors++; $display("FAIL poszero_vs_negzero: got data=%h imp=%b expected 00000000 imp=1", d, imp);
    end
  endtask

  task automatic test_int_compare();
    logic [31:0] d, di;
    logic v, imp, impi;
    upd(6'd21, 32'hFFFFFFFE, 1'b0);
    upd(6'd21, 32'h00000001, 1'b1);
    rd(6'd21, d, v, imp, di, impi);
    checks++; if (di !== 32'h00000001 || impi !== 1'b1) begin
      errors++; $display("FAIL int_neg_to_pos: got data=%h imp=%b expected 00000001 imp=1", di, impi);
    end
    upd(6'd21, 32'h00000005, 1'b0);
    upd(6'd21, 32'hFFFFFFFD, 1'b1);
    rd(6'd21, d, v, imp, di, impi);
    checks++; if (di !== 32'h00000005 || impi !== 1'b0) begin
      errors++; $display("FAIL int_pos_vs_neg: got data=%h imp=%b expected 00000005 imp=0", di, impi);
    end
  endtask

  task automatic test_clear_squash();
    logic [31:0] d, di;
    logic v, imp, impi;
    int n, bad;
    upd(6'd3, 32'h3F800000, 1'b0);
    cyc();
    upd(6'd3, 32'h40A00000, 1'b1);
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    checks++; if (imp_f !== 1'b0 || busy_f !== 1'b1) begin
      errors++; $display("FAIL clear_squash: got imp=%b busy=%b expected imp=0 busy=1", imp_f, busy_f);
    end
    i_rd_en = 1'b1; i_rd_addr = 6'd3;
    i_upd_en = 1'b1; i_upd_addr = 6'd7; i_upd_data = 32'hAAAA5555; i_upd_mode = 1'b0;
    n = 0; bad = 0;
    while (busy_f && n < 200) begin
      cyc();
      n++;
      if (rd_valid_f || imp_f) bad++;
    end
    i_rd_en = 1'b0; i_upd_en = 1'b0;
    checks++; if (n !== 64) begin errors++; $display("FAIL clear_sweep_len: got %0d expected 64", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_ignored: got %0d active cycles expected 0", bad); end
    rd(6'd3, d, v, imp, di, impi);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_addr3: got %h expected 00000000", d); end
    rd(6'd7, d, v, imp, di, impi);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL busy_upd_addr7: got %h expected 00000000", d); end
    rd(6'd5, d, v, imp, di, impi);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_addr5: got %h expected 00000000", d); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] d, di;
    logic v, imp, impi;
    int n;
    upd(6'd30, 32'hDEADBEEF, 1'b0);
    rd(6'd30, d, v, imp, di, impi);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_read: got %h expected DEADBEEF", d); end
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    repeat (20) cyc();
    i_rst_n = 1'b0;
    #1;
    checks++; if (rd_data_f !== 32'h0 || rd_valid_f !== 1'b0 || busy_f !== 1'b1) begin
      errors++; $display("FAIL mid_sweep_reset: got data=%h valid=%b busy=%b expected 00000000 0 1", rd_data_f, rd_valid_f, busy_f);
    end
    cyc();
    i_rst_n = 1'b1;
    count_busy(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL restart_sweep_len: got %0d expected 64", n); end
    rd(6'd30, d, v, imp, di, impi);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin
      errors++; $display("FAIL post_reset_read: got data=%h valid=%b expected 00000000 1", d, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plain_max();
    test_back_to_back();
    test_same_cycle();
    test_negative();
    test_int_compare();
    test_clear_squash();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qmax_update_table.md
Name: qmax_update_table

Overview:
Parametrised successor to the single-port Q-max BRAM table. Holds one max-Q value per state and supports plain writes and atomic read-compare-write "max" updates through a 2-stage hazard-forwarded pipeline, alongside a 1-cycle registered read port. Contents are initialised by a hardware clear sweep after reset or on request. Sits between the Q-update datapath (producer) and the action-selection / TD-target logic (consumer).

Parameters:
ADDR_WIDTH, 6, state index width
DATA_WIDTH, 32, Q-value width
DEPTH, 64, number of entries; must be <= 2^ADDR_WIDTH
IS_FLOAT, 1, 1 = compare as IEEE-754 single; 0 = compare as signed two's complement
INIT_VALUE, 0, value written to every entry by the clear sweep

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_clear  in  1  single-cycle request to start a clear sweep
o_busy  out  1  high while clear sweep is running; rd/upd inputs ignored
i_rd_en  in  1  read request
i_rd_addr  in  ADDR_WIDTH  read address
o_rd_data  out  DATA_WIDTH  read data, registered
o_rd_valid  out  1  o_rd_data valid, 1 cycle after accepted read
i_upd_en  in  1  update request
i_upd_addr  in  ADDR_WIDTH  update address
i_upd_data  in  DATA_WIDTH  candidate value
i_upd_mode  in  1  0 = unconditional write; 1 = write max(stored, candidate)
o_improved  out  1  pulse: max-mode update changed the stored value

Behaviour:
- Reset (async assert, sync deassert to next edge): o_rd_data=0, o_rd_valid=0, o_improved=0, o_busy=1, pipeline stage S1 invalid, sweep counter=0, FSM=CLEAR. Reset mid-sweep or mid-update restarts the sweep from address 0; in-flight update is lost.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle write INIT_VALUE to mem[cnt], cnt++; after writing DEPTH-1 go IDLE. Exactly DEPTH cycles. o_busy=1 throughout, 0 in IDLE.
  - IDLE: i_clear=1 -> CLEAR next cycle, cnt=0; any S1 update in the same cycle is squashed (not written), o_improved stays 0.
- Inputs accepted only when FSM=IDLE and i_clear=0; otherwise i_rd_en/i_upd_en are ignored (no o_rd_valid, no write).
- Read: accepted at edge N -> o_rd_data/o_rd_valid at edge N+1 (o_rd_valid is a 1-cycle pulse per accept; back-to-back reads give continuous valid). Addresses >= DEPTH return INIT_VALUE.
- Update pipeline: edge N accepts into S0 (register addr/data/mode, sync-read old value); during cycle after N, S1 compares; write committed at edge N+1.
  - mode 0: new = candidate. mode 1: new = candidate if candidate > old, else old; write suppressed when not greater.
  - o_improved=1 at edge N+1 iff mode 1 and candidate > old. Addresses >= DEPTH: dropped, no write, o_improved=0.
- Compare: IS_FLOAT=0 signed compare. IS_FLOAT=1: key = sign ? ~x : x ^ MSB; unsigned compare of keys (gives -0 < +0; NaN ordering undefined, not required).
- Hazards / forwarding (single write port, one read per port per cycle):
  - Update-after-update, same address, back-to-back: second update's "old" is the first's committed value (forward from S1).
  - Read accepted in the same cycle as an S1 commit to the same address returns the committed value.
  - Net rule: every read/update sees all updates accepted in strictly earlier cycles. Simultaneous read + update accepted same cycle, same address: read returns the pre-update value.

Test Plan:
- Reset release -> o_busy=1 for exactly 64 cycles, then 0; reads of addr 0, 37, 63 return 0x00000000 with o_rd_valid one cycle after request.
- upd mode 0 addr 5 = 0x40400000 (3.0); read addr 5 next cycle -> 0x40400000; mode 1 with 0x40000000 (2.0) -> stored stays 3.0, o_improved=0; mode 1 with 0x40800000 (4.0) -> 4.0, o_improved=1.
- Back-to-back max updates addr 9 with 1.0, 0.5, 2.0 on consecutive cycles from 0 -> final 2.0; o_improved pattern 1,0,1.
- Negative floats: store 0xC0000000 (-2.0), max-update 0xBF800000 (-1.0) -> stored -1.0; IS_FLOAT=0 build, store 0xFFFFFFFE, max 0x00000001 -> 0x00000001.
- i_clear pulsed while an update to addr 3 is in S1 -> write squashed, o_busy 64 cycles, addr 3 reads 0; rd/upd during busy produce no o_rd_valid and no change.
- i_rst_n asserted mid-sweep at cnt=20 -> outputs reset immediately; after release sweep restarts and lasts a full 64 cycles.
